// File: rtl/wb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// wb_mem_arbiter
//
// Purpose:
//   Shares the instruction and data memories between the CPU core and the
//   UART Wishbone bridge. The core owns both memories by default. A bridge
//   cycle freezes the core, lets the core's in-flight access drain for one
//   cycle, performs exactly one access to the memory picked by select_mem,
//   then hands ownership back once the bridge drops its strobe.
//
// Optional feature (compile-time macro):
//   WB_ACK_TIMEOUT_EN - bounds the wait for a memory ack to TIMEOUT_CYCLES
//                       cycles; an expired wait pulses wbs_err_o instead of
//                       wbs_ack_o. Without it the wait is unbounded and
//                       wbs_err_o is constant 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   select_mem               bridge target (0 = instr mem, 1 = data mem)
//   wbs_cyc_i .. wbs_dat_i   bridge Wishbone slave request
//   wbs_dat_o                bridge read data (registered)
//   wbs_ack_o, wbs_err_o     bridge single-cycle ack / error (registered)
//   core_*_i                 core fetch address and load/store request
//   core_stall_o             pipeline freeze (registered)
//   imem_*, dmem_*           Wishbone master ports to the two memories
//                            (stb doubles as cyc)
//   mem_wdat_o               write data shared by both memories
// ----------------------------------------------------------------------------
module wb_mem_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      select_mem,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [ADDR_WIDTH-1:0]     wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]     wbs_dat_i,
    output logic [DATA_WIDTH-1:0]     wbs_dat_o,
    output logic                      wbs_ack_o,
    output logic                      wbs_err_o,

    input  logic [ADDR_WIDTH-1:0]     core_pc_i,
    input  logic                      core_mem_write_i,
    input  logic [ADDR_WIDTH-1:0]     core_data_addr_i,
    input  logic [DATA_WIDTH-1:0]     core_write_data_i,
    output logic                      core_stall_o,

    output logic [MEM_ADDR_WIDTH-1:0] imem_adr_o,
    output logic                      imem_we_o,
    output logic                      imem_stb_o,
    input  logic [DATA_WIDTH-1:0]     imem_dat_i,
    input  logic                      imem_ack_i,

    output logic [MEM_ADDR_WIDTH-1:0] dmem_adr_o,
    output logic                      dmem_we_o,
    output logic                      dmem_stb_o,
    input  logic [DATA_WIDTH-1:0]     dmem_dat_i,
    input  logic                      dmem_ack_i,

    output logic [DATA_WIDTH-1:0]     mem_wdat_o
);

    typedef enum logic [1:0] {
        S_CORE    = 2'd0,
        S_DRAIN   = 2'd1,
        S_BR_REQ  = 2'd2,
        S_BR_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Bridge request captured when it is accepted in S_CORE.
    logic [MEM_ADDR_WIDTH-1:0] req_adr;
    logic [DATA_WIDTH-1:0]     req_dat;
    logic                      req_we;
    logic                      req_sel;

    logic                      bus_req_c;
    logic                      tgt_ack_c;
    logic [DATA_WIDTH-1:0]     tgt_dat_c;
    logic                      timeout_c;

    assign bus_req_c = wbs_cyc_i & wbs_stb_i;

    // Ack/data of the memory selected for the current bridge access.
    assign tgt_ack_c = req_sel ? dmem_ack_i : imem_ack_i;
    assign tgt_dat_c = req_sel ? dmem_dat_i : imem_dat_i;

    // Upper address bits are dropped: memories only decode MEM_ADDR_WIDTH bits.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wbs_adr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                                core_pc_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                                core_data_addr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

`ifdef WB_ACK_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] to_cnt;

    // Counts unacknowledged cycles spent in S_BR_REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state != S_BR_REQ) begin
            to_cnt <= '0;
        end else if (!tgt_ack_c) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    // Fires at the end of the TIMEOUT_CYCLES-th BR_REQ cycle; an ack in that
    // same cycle still wins.
    assign timeout_c = (state == S_BR_REQ) && !tgt_ack_c &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Error pulse follows the expiring cycle by one clock, like the ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbs_err_o <= 1'b0;
        end else begin
            wbs_err_o <= timeout_c;
        end
    end
`else
    assign timeout_c = 1'b0;
    assign wbs_err_o = 1'b0;

    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
`endif

    // State register, request capture and registered bridge/core outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_CORE;
            req_adr      <= '0;
            req_dat      <= '0;
            req_we       <= 1'b0;
            req_sel      <= 1'b0;
            wbs_dat_o    <= '0;
            wbs_ack_o    <= 1'b0;
            core_stall_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            // Stall tracks ownership: raised on acceptance, dropped on return.
            core_stall_o <= (state_nxt != S_CORE);
            wbs_ack_o    <= (state == S_BR_REQ) && tgt_ack_c;

            if ((state == S_CORE) && bus_req_c) begin
                req_adr <= wbs_adr_i[MEM_ADDR_WIDTH-1:0];
                req_dat <= wbs_dat_i;
                req_we  <= wbs_we_i;
                req_sel <= select_mem;
            end

            // Read data is captured for writes too; the timeout path leaves it.
            if ((state == S_BR_REQ) && tgt_ack_c) begin
                wbs_dat_o <= tgt_dat_c;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_CORE: begin
                if (bus_req_c) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nxt = S_BR_REQ;
            end
            S_BR_REQ: begin
                if (tgt_ack_c || timeout_c) begin
                    state_nxt = S_BR_DONE;
                end
            end
            S_BR_DONE: begin
                // Holding stb after the ack must not start a second access.
                if (!wbs_stb_i) begin
                    state_nxt = S_CORE;
                end
            end
            default: begin
                state_nxt = S_CORE;
            end
        endcase
    end

    // Memory-side steering; everything is forced low while reset is held.
    always_comb begin
        imem_adr_o = '0;
        imem_we_o  = 1'b0;
        imem_stb_o = 1'b0;
        dmem_adr_o = '0;
        dmem_we_o  = 1'b0;
        dmem_stb_o = 1'b0;
        mem_wdat_o = '0;

        if (!rst) begin
            case (state)
                // DRAIN keeps the core's request on the bus so an access the
                // memory accepted late still completes before the bridge.
                S_CORE, S_DRAIN: begin
                    imem_adr_o = core_pc_i[MEM_ADDR_WIDTH-1:0];
                    imem_stb_o = 1'b1;
                    dmem_adr_o = core_data_addr_i[MEM_ADDR_WIDTH-1:0];
                    dmem_we_o  = core_mem_write_i;
                    dmem_stb_o = 1'b1;
                    mem_wdat_o = core_write_data_i;
                end
                S_BR_REQ: begin
                    imem_adr_o = req_adr;
                    dmem_adr_o = req_adr;
                    mem_wdat_o = req_dat;
                    if (req_sel) begin
                        dmem_stb_o = 1'b1;
                        dmem_we_o  = req_we;
                    end else begin
                        imem_stb_o = 1'b1;
                        imem_we_o  = req_we;
                    end
                end
                default: begin
                    // S_BR_DONE: both memories idle, bus values parked.
                    imem_adr_o = req_adr;
                    dmem_adr_o = req_adr;
                    mem_wdat_o = req_dat;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_mem_arbiter
//
// Bench for wb_mem_arbiter. Two behavioural Wishbone memories with adjustable
// ack latency sit on the memory ports. Expected bridge responses come from a
// per-memory array of intended contents; they are queued when a request is
// issued and consumed by an independent monitor on every ack/err.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wb_mem_arbiter;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned MAW = 10;
    localparam int unsigned TO  = 16;
    localparam int unsigned DEPTH = 1 << MAW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           select_mem = 1'b0;
    logic           wbs_cyc_i = 1'b0;
    logic           wbs_stb_i = 1'b0;
    logic           wbs_we_i = 1'b0;
    logic [AW-1:0]  wbs_adr_i = '0;
    logic [DW-1:0]  wbs_dat_i = '0;
    logic [DW-1:0]  wbs_dat_o;
    logic           wbs_ack_o;
    logic           wbs_err_o;
    logic [AW-1:0]  core_pc_i = '0;
    logic           core_mem_write_i = 1'b0;
    logic [AW-1:0]  core_data_addr_i = '0;
    logic [DW-1:0]  core_write_data_i = '0;
    logic           core_stall_o;
    logic [MAW-1:0] imem_adr_o;
    logic           imem_we_o;
    logic           imem_stb_o;
    logic [DW-1:0]  imem_dat_i;
    logic           imem_ack_i;
    logic [MAW-1:0] dmem_adr_o;
    logic           dmem_we_o;
    logic           dmem_stb_o;
    logic [DW-1:0]  dmem_dat_i;
    logic           dmem_ack_i;
    logic [DW-1:0]  mem_wdat_o;

    wb_mem_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .MEM_ADDR_WIDTH (MAW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .select_mem        (select_mem),
        .wbs_cyc_i         (wbs_cyc_i),
        .wbs_stb_i         (wbs_stb_i),
        .wbs_we_i          (wbs_we_i),
        .wbs_adr_i         (wbs_adr_i),
        .wbs_dat_i         (wbs_dat_i),
        .wbs_dat_o         (wbs_dat_o),
        .wbs_ack_o         (wbs_ack_o),
        .wbs_err_o         (wbs_err_o),
        .core_pc_i         (core_pc_i),
        .core_mem_write_i  (core_mem_write_i),
        .core_data_addr_i  (core_data_addr_i),
        .core_write_data_i (core_write_data_i),
        .core_stall_o      (core_stall_o),
        .imem_adr_o        (imem_adr_o),
        .imem_we_o         (imem_we_o),
        .imem_stb_o        (imem_stb_o),
        .imem_dat_i        (imem_dat_i),
        .imem_ack_i        (imem_ack_i),
        .dmem_adr_o        (dmem_adr_o),
        .dmem_we_o         (dmem_we_o),
        .dmem_stb_o        (dmem_stb_o),
        .dmem_dat_i        (dmem_dat_i),
        .dmem_ack_i        (dmem_ack_i),
        .mem_wdat_o        (mem_wdat_o)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- behavioural memories ----------------
    logic [DW-1:0] imem_arr [DEPTH];
    logic [DW-1:0] dmem_arr [DEPTH];
    logic [DW-1:0] imem_exp [DEPTH];
    logic [DW-1:0] dmem_exp [DEPTH];
    int  imem_wait = 0;
    int  dmem_wait = 0;
    int  mem_lat   = 0;
    bit  mem_block = 1'b0;

    assign imem_ack_i = imem_stb_o && !mem_block && (imem_wait >= mem_lat);
    assign dmem_ack_i = dmem_stb_o && !mem_block && (dmem_wait >= mem_lat);
    assign imem_dat_i = imem_arr[imem_adr_o];
    assign dmem_dat_i = dmem_arr[dmem_adr_o];

    always @(posedge clk) begin
        if (cyc_cnt == 0) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                imem_arr[i] <= imem_exp[i];
                dmem_arr[i] <= dmem_exp[i];
            end
        end else begin
            imem_wait <= (imem_stb_o && !imem_ack_i) ? imem_wait + 1 : 0;
            dmem_wait <= (dmem_stb_o && !dmem_ack_i) ? dmem_wait + 1 : 0;
            if (imem_stb_o && imem_ack_i && imem_we_o) imem_arr[imem_adr_o] <= mem_wdat_o;
            if (dmem_stb_o && dmem_ack_i && dmem_we_o) dmem_arr[dmem_adr_o] <= mem_wdat_o;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DW-1:0] data;
        int            req_cycle;
        int            min_lat;
        int            max_lat;
        bit            is_err;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] last_dat = '0;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc_cnt);
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (wbs_ack_o || wbs_err_o)) begin
            if (exp_q.size() == 0) begin
                check("spurious_resp", 64'({wbs_ack_o, wbs_err_o}), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_kind", 64'({wbs_ack_o, wbs_err_o}), e.is_err ? 64'd1 : 64'd2);
                check("resp_data", 64'(wbs_dat_o), 64'(e.data));
                check_range("resp_latency", cyc_cnt - e.req_cycle, e.min_lat, e.max_lat);
            end
        end
    end

    // One bridge access; must be called at a negedge. blocked = memory never acks.
    task automatic bridge_access(input logic sel, input logic we, input logic [AW-1:0] adr,
                                 input logic [DW-1:0] dat, input int lat, input int hold,
                                 input bit chk_req, input bit blocked);
        exp_t           e;
        int             k;
        bit             done;
        logic [MAW-1:0] a;
        a = adr[MAW-1:0];
        mem_lat   = lat;
        mem_block = blocked;
        select_mem = sel;
        wbs_we_i   = we;
        wbs_adr_i  = adr;
        wbs_dat_i  = dat;
        wbs_cyc_i  = 1'b1;
        wbs_stb_i  = 1'b1;

        e.req_cycle = cyc_cnt;
        e.is_err    = blocked;
        if (blocked) begin
            e.data    = last_dat;
            e.min_lat = int'(TO) + 2;
            e.max_lat = int'(TO) + 2;
        end else begin
            e.data    = sel ? dmem_exp[a] : imem_exp[a];
            e.min_lat = 3;
            e.max_lat = 3 + lat;
            last_dat  = e.data;
            if (we) begin
                if (sel) dmem_exp[a] = dat;
                else     imem_exp[a] = dat;
            end
        end
        exp_q.push_back(e);

        k = 0;
        done = 1'b0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
            check("stall_busy", 64'(core_stall_o), 64'd1);
            if (chk_req && k == 2) begin
                if (sel) begin
                    check("req_dmem_stb", 64'(dmem_stb_o), 64'd1);
                    check("req_dmem_adr", 64'(dmem_adr_o), 64'(a));
                    check("req_dmem_we",  64'(dmem_we_o), 64'(we));
                    check("req_imem_stb", 64'(imem_stb_o), 64'd0);
                end else begin
                    check("req_imem_stb", 64'(imem_stb_o), 64'd1);
                    check("req_imem_adr", 64'(imem_adr_o), 64'(a));
                    check("req_imem_we",  64'(imem_we_o), 64'(we));
                    check("req_dmem_stb", 64'(dmem_stb_o), 64'd0);
                end
                if (we) check("req_wdat", 64'(mem_wdat_o), 64'(dat));
            end
            if (wbs_ack_o || wbs_err_o) done = 1'b1;
        end
        if (!done) begin
            check("resp_wait_expired", 64'(k), 64'd0);
            exp_q.delete();
        end

        // A core store issued while frozen must never reach memory.
        core_mem_write_i  = 1'b1;
        core_data_addr_i  = adr;
        core_write_data_i = ~dat;
        repeat (hold) begin
            @(negedge clk);
            check("stall_hold", 64'(core_stall_o), 64'd1);
            check("hold_imem_idle", 64'(imem_stb_o), 64'd0);
            check("hold_dmem_idle", 64'(dmem_stb_o), 64'd0);
        end
        wbs_cyc_i        = 1'b0;
        wbs_stb_i        = 1'b0;
        core_mem_write_i = 1'b0;
        mem_block        = 1'b0;

        @(negedge clk);
        check("stall_released", 64'(core_stall_o), 64'd0);
        check("core_imem_adr", 64'(imem_adr_o), 64'(core_pc_i[MAW-1:0]));
        check("core_imem_ctl", 64'({imem_stb_o, imem_we_o}), 64'd2);
        check("core_dmem_adr", 64'(dmem_adr_o), 64'(core_data_addr_i[MAW-1:0]));
        check("core_dmem_ctl", 64'({dmem_stb_o, dmem_we_o}), 64'({1'b1, core_mem_write_i}));
    endtask

    initial begin
        logic [AW-1:0] adr;
        for (int i = 0; i < int'(DEPTH); i++) begin
            imem_exp[i] = $urandom;
            dmem_exp[i] = $urandom;
        end
        dmem_exp[32'h20] = 32'h1234_5678;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dat", 64'(wbs_dat_o), 64'd0);
        check("rst_ack", 64'(wbs_ack_o), 64'd0);
        check("rst_err", 64'(wbs_err_o), 64'd0);
        check("rst_stall", 64'(core_stall_o), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed: imem write, dmem read, store-in-flight, long stb hold.
        bridge_access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        bridge_access(1'b1, 1'b0, 32'h20, 32'h0, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        core_mem_write_i  = 1'b1;
        core_data_addr_i  = 32'h4;
        core_write_data_i = 32'h0000_CAFE;
        dmem_exp[4]       = 32'h0000_CAFE;
        bridge_access(1'b1, 1'b0, 32'h4, 32'h0, 1, 0, 1'b1, 1'b0);
        @(negedge clk);
        bridge_access(1'b0, 1'b0, 32'h10, 32'h0, 0, 5, 1'b0, 1'b0);

        // Reset in the middle of a bridge access that never gets acked.
        @(negedge clk);
        mem_block  = 1'b1;
        select_mem = 1'b1;
        wbs_we_i   = 1'b0;
        wbs_adr_i  = 32'h8;
        wbs_cyc_i  = 1'b1;
        wbs_stb_i  = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_rst_stall", 64'(core_stall_o), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_dat", 64'(wbs_dat_o), 64'd0);
        check("midrst_ack_err", 64'({wbs_ack_o, wbs_err_o}), 64'd0);
        check("midrst_stall", 64'(core_stall_o), 64'd0);
        check("midrst_mem_stb", 64'({imem_stb_o, dmem_stb_o}), 64'd0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        mem_block = 1'b0;
        last_dat  = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("postrst_stall", 64'(core_stall_o), 64'd0);
            check("postrst_imem_stb", 64'(imem_stb_o), 64'd1);
        end

`ifdef WB_ACK_TIMEOUT_EN
        @(negedge clk);
        bridge_access(1'b0, 1'b0, 32'h30, 32'h0, 0, 2, 1'b0, 1'b1);
`endif

        // Randomised accesses over a small address pool so reads hit writes.
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            core_pc_i         = $urandom;
            core_data_addr_i  = $urandom;
            core_write_data_i = $urandom;
            core_mem_write_i  = 1'b0;
            adr = ($urandom & 32'hFFFF_FC00) | AW'($urandom_range(0, 7) << 2);
            bridge_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), adr, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish by %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
